ex_stage: RTL and testbench

//  EX pipeline stage of the MIPS core: the driving end of alu_unit. Per cycle:
//  - takes the ID/EX bundle
//  - resolves operand forwarding from MEM and WB
//  - decodes ALUOp/funct into the 3-bit ALU opcode
//  - instantiates alu_unit, computes the branch decision and target
//  - registers everything into the EX/MEM pipeline register (with stall and flush).

---
 rtl/mips_pkg.sv | 27 ++
 rtl/alu_unit.sv | 28 ++
 rtl/ex_stage.sv | 129 ++++++++++++
 tb/tb_ex_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: ALU opcodes, ALUOp encodings and R-type funct codes.
package mips_pkg;

    // 3-bit opcode consumed by alu_unit
    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSlt = 3'b100
    } alu_opcode_e;

    // 2-bit ALUOp produced by the main decoder in ID
    typedef enum logic [1:0] {
        AluOpAdd     = 2'b00,
        AluOpSub     = 2'b01,
        AluOpFunct   = 2'b10,
        AluOpIllegal = 2'b11
    } alu_op_e;

    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctAnd = 6'b100100;
    localparam logic [5:0] FunctOr  = 6'b100101;
    localparam logic [5:0] FunctSlt = 6'b101010;

endpackage

// File: rtl/alu_unit.sv
// Combinational integer ALU: add/sub wrap, signed set-less-than, zero flag.
module alu_unit
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_opcode_e       alu_opcode,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    // Select the operation and derive the zero flag from the result
    always_comb begin
        result = '0;
        unique case (alu_opcode)
            AluAdd:  result = a + b;
            AluSub:  result = a - b;
            AluAnd:  result = a & b;
            AluOr:   result = a | b;
            AluSlt:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/ex_stage.sv
// EX pipeline stage: operand forwarding, ALU decode, branch resolution and the
// EX/MEM pipeline register with stall and flush.
module ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              id_valid,
    input  logic [1:0]        id_alu_op,
    input  logic [5:0]        id_funct,
    input  logic              id_alu_src,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_branch,
    input  logic              mem_fwd_we,
    input  logic              wb_fwd_we,
    input  logic [REG_AW-1:0] mem_fwd_rd,
    input  logic [REG_AW-1:0] wb_fwd_rd,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic [DATA_W-1:0] wb_fwd_data,
    output logic              exm_valid,
    output logic              exm_reg_write,
    output logic              exm_mem_read,
    output logic              exm_mem_write,
    output logic [DATA_W-1:0] exm_alu_result,
    output logic              exm_zero,
    output logic [DATA_W-1:0] exm_store_data,
    output logic [REG_AW-1:0] exm_rd,
    output logic              exm_br_taken,
    output logic [DATA_W-1:0] exm_br_target,
    output logic              exm_illegal
);

    logic [DATA_W-1:0] fwd_a, fwd_b, op_b;
    logic [DATA_W-1:0] alu_result, br_target;
    logic              alu_zero, illegal;
    alu_opcode_e       alu_opcode;

    // Forwarding: MEM beats WB beats register file; r0 is never forwarded
    always_comb begin
        fwd_a = id_rs_data;
        if (wb_fwd_we && (wb_fwd_rd == id_rs) && (id_rs != '0)) fwd_a = wb_fwd_data;
        if (mem_fwd_we && (mem_fwd_rd == id_rs) && (id_rs != '0)) fwd_a = mem_fwd_data;
        fwd_b = id_rt_data;
        if (wb_fwd_we && (wb_fwd_rd == id_rt) && (id_rt != '0)) fwd_b = wb_fwd_data;
        if (mem_fwd_we && (mem_fwd_rd == id_rt) && (id_rt != '0)) fwd_b = mem_fwd_data;
        op_b = id_alu_src ? id_imm : fwd_b;
    end

    // ALUOp/funct decode; anything undecodable falls back to ADD and is flagged
    always_comb begin
        alu_opcode = AluAdd;
        illegal    = 1'b0;
        unique case (alu_op_e'(id_alu_op))
            AluOpAdd: alu_opcode = AluAdd;
            AluOpSub: alu_opcode = AluSub;
            AluOpFunct: begin
                case (id_funct)
                    FunctAdd: alu_opcode = AluAdd;
                    FunctSub: alu_opcode = AluSub;
                    FunctAnd: alu_opcode = AluAnd;
                    FunctOr:  alu_opcode = AluOr;
                    FunctSlt: alu_opcode = AluSlt;
                    default:  illegal    = 1'b1;
                endcase
            end
            AluOpIllegal: illegal = 1'b1;
            default:      illegal = 1'b1;
        endcase
    end

    alu_unit #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a          (fwd_a),
        .b          (op_b),
        .alu_opcode (alu_opcode),
        .result     (alu_result),
        .zero       (alu_zero)
    );

    // Target is always computed; only the taken flag depends on id_branch
    always_comb begin
        br_target = id_pc_plus4 + (id_imm << 2);
    end

    // EX/MEM register: reset/flush clear, stall holds, invalid bundle loads a bubble
    always_ff @(posedge clk) begin
        if (rst || flush_in || (!stall_in && !id_valid)) begin
            exm_valid      <= 1'b0;
            exm_reg_write  <= 1'b0;
            exm_mem_read   <= 1'b0;
            exm_mem_write  <= 1'b0;
            exm_alu_result <= '0;
            exm_zero       <= 1'b0;
            exm_store_data <= '0;
            exm_rd         <= '0;
            exm_br_taken   <= 1'b0;
            exm_br_target  <= '0;
            exm_illegal    <= 1'b0;
        end else if (!stall_in) begin
            exm_valid      <= 1'b1;
            exm_reg_write  <= id_reg_write & ~illegal;
            exm_mem_read   <= id_mem_read;
            exm_mem_write  <= id_mem_write & ~illegal;
            exm_alu_result <= alu_result;
            exm_zero       <= alu_zero;
            exm_store_data <= fwd_b;
            exm_rd         <= id_rd;
            exm_br_taken   <= id_branch & alu_zero;
            exm_br_target  <= br_target;
            exm_illegal    <= illegal;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver pushes the hand-computed EX/MEM
// contents expected after each edge; the monitor pops and compares after it.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall_in, flush_in, id_valid, id_alu_src;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc_plus4;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_reg_write, id_mem_read, id_mem_write, id_branch;
    logic        mem_fwd_we, wb_fwd_we;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        exm_valid, exm_reg_write, exm_mem_read, exm_mem_write;
    logic [31:0] exm_alu_result, exm_store_data, exm_br_target;
    logic        exm_zero, exm_br_taken, exm_illegal;
    logic [4:0]  exm_rd;

    always #5 clk = ~clk;

    ex_stage #(
        .DATA_W (32),
        .REG_AW (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_in       (stall_in),
        .flush_in       (flush_in),
        .id_valid       (id_valid),
        .id_alu_op      (id_alu_op),
        .id_funct       (id_funct),
        .id_alu_src     (id_alu_src),
        .id_rs_data     (id_rs_data),
        .id_rt_data     (id_rt_data),
        .id_imm         (id_imm),
        .id_pc_plus4    (id_pc_plus4),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .id_mem_write   (id_mem_write),
        .id_branch      (id_branch),
        .mem_fwd_we     (mem_fwd_we),
        .wb_fwd_we      (wb_fwd_we),
        .mem_fwd_rd     (mem_fwd_rd),
        .wb_fwd_rd      (wb_fwd_rd),
        .mem_fwd_data   (mem_fwd_data),
        .wb_fwd_data    (wb_fwd_data),
        .exm_valid      (exm_valid),
        .exm_reg_write  (exm_reg_write),
        .exm_mem_read   (exm_mem_read),
        .exm_mem_write  (exm_mem_write),
        .exm_alu_result (exm_alu_result),
        .exm_zero       (exm_zero),
        .exm_store_data (exm_store_data),
        .exm_rd         (exm_rd),
        .exm_br_taken   (exm_br_taken),
        .exm_br_target  (exm_br_target),
        .exm_illegal    (exm_illegal)
    );

    typedef struct {
        string       name;
        logic        valid, rw, mr, mw, zero, br, ill;
        logic [31:0] res, store, tgt;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(string name, logic valid, logic rw, logic mr, logic mw,
                                logic [31:0] res, logic zero, logic [31:0] store,
                                logic [4:0] rd, logic br, logic [31:0] tgt, logic ill);
        exp_t e;
        e.name = name; e.valid = valid; e.rw = rw; e.mr = mr; e.mw = mw;
        e.res = res; e.zero = zero; e.store = store; e.rd = rd;
        e.br = br; e.tgt = tgt; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t zero_exp(string name);
        return mk(name, 0, 0, 0, 0, 32'h0, 0, 32'h0, 5'd0, 0, 32'h0, 0);
    endfunction

    task automatic push(exp_t e);
        exp_q.push_back(e);
        last_exp = e;
    endtask

    // Move to the drive point of the next cycle
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        rst = 0; stall_in = 0; flush_in = 0; id_valid = 0; id_alu_src = 0;
        id_alu_op = 2'b00; id_funct = 6'd0; id_rs_data = 0; id_rt_data = 0;
        id_imm = 0; id_pc_plus4 = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_branch = 0;
        mem_fwd_we = 0; wb_fwd_we = 0; mem_fwd_rd = 0; wb_fwd_rd = 0;
        mem_fwd_data = 0; wb_fwd_data = 0;
    endtask

    task automatic bundle(logic [1:0] op, logic [5:0] funct, logic src, logic [31:0] rs_d,
                          logic [31:0] rt_d, logic [31:0] imm, logic [31:0] pc,
                          logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                          logic rw, logic mr, logic mw, logic br);
        id_valid = 1; id_alu_op = op; id_funct = funct; id_alu_src = src;
        id_rs_data = rs_d; id_rt_data = rt_d; id_imm = imm; id_pc_plus4 = pc;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_branch = br;
    endtask

    // Monitor: EX/MEM updates every edge, so one expectation is consumed per cycle
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (exm_valid !== e.valid || exm_reg_write !== e.rw || exm_mem_read !== e.mr ||
                    exm_mem_write !== e.mw || exm_alu_result !== e.res || exm_zero !== e.zero ||
                    exm_store_data !== e.store || exm_rd !== e.rd || exm_br_taken !== e.br ||
                    exm_br_target !== e.tgt || exm_illegal !== e.ill) begin
                    errors++;
                    $display("FAIL %s: got v=%b rw=%b mr=%b mw=%b res=%h z=%b st=%h rd=%0d br=%b tgt=%h ill=%b ; expected v=%b rw=%b mr=%b mw=%b res=%h z=%b st=%h rd=%0d br=%b tgt=%h ill=%b",
                             e.name, exm_valid, exm_reg_write, exm_mem_read, exm_mem_write,
                             exm_alu_result, exm_zero, exm_store_data, exm_rd, exm_br_taken,
                             exm_br_target, exm_illegal, e.valid, e.rw, e.mr, e.mw, e.res,
                             e.zero, e.store, e.rd, e.br, e.tgt, e.ill);
                end
            end
        end
    end

    localparam logic [1:0] OpAdd = 2'b00, OpSub = 2'b01, OpFn = 2'b10, OpBad = 2'b11;

    initial begin
        clear_inputs();
        tick(); rst = 1; bundle(OpFn, 6'h20, 0, 1, 2, 0, 0, 1, 2, 4, 1, 0, 0, 0);
        push(zero_exp("reset"));

        tick(); clear_inputs(); bundle(OpFn, 6'h20, 0, 5, 10, 0, 32'h40, 1, 2, 4, 1, 0, 0, 0);
        push(mk("r_add", 1, 1, 0, 0, 32'd15, 0, 32'd10, 5'd4, 0, 32'h40, 0));

        tick(); clear_inputs(); bundle(OpFn, 6'h22, 0, 1, 5, 0, 0, 3, 6, 7, 1, 0, 0, 0);
        mem_fwd_we = 1; mem_fwd_rd = 3; mem_fwd_data = 20;
        wb_fwd_we = 1; wb_fwd_rd = 3; wb_fwd_data = 99;
        push(mk("fwd_mem_prio", 1, 1, 0, 0, 32'd15, 0, 32'd5, 5'd7, 0, 32'h0, 0));

        tick(); mem_fwd_rd = 9;
        push(mk("fwd_wb_only", 1, 1, 0, 0, 32'd94, 0, 32'd5, 5'd7, 0, 32'h0, 0));

        tick(); clear_inputs(); bundle(OpFn, 6'h22, 0, 8, 5, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        mem_fwd_we = 1; mem_fwd_rd = 0; mem_fwd_data = 20;
        wb_fwd_we = 1; wb_fwd_rd = 0; wb_fwd_data = 99;
        push(mk("fwd_r0_blocked", 1, 1, 0, 0, 32'd3, 0, 32'd5, 5'd7, 0, 32'h0, 0));

        tick(); clear_inputs(); bundle(OpFn, 6'h22, 0, 50, 1, 0, 0, 2, 6, 7, 1, 0, 0, 0);
        mem_fwd_we = 1; mem_fwd_rd = 6; mem_fwd_data = 20;
        push(mk("fwd_rt_mem", 1, 1, 0, 0, 32'd30, 0, 32'd20, 5'd7, 0, 32'h0, 0));

        tick(); clear_inputs(); bundle(OpSub, 6'h00, 0, 7, 7, 4, 32'h100, 1, 2, 0, 0, 0, 0, 1);
        push(mk("beq_taken", 1, 0, 0, 0, 32'd0, 1, 32'd7, 5'd0, 1, 32'h110, 0));

        tick(); clear_inputs();
        bundle(OpSub, 6'h00, 0, 7, 3, 32'hFFFF_FFFF, 32'h0, 1, 2, 0, 0, 0, 0, 1);
        push(mk("beq_neg_imm", 1, 0, 0, 0, 32'd4, 0, 32'd3, 5'd0, 0, 32'hFFFF_FFFC, 0));

        tick(); clear_inputs(); bundle(OpFn, 6'h2A, 0, 32'hFFFF_FFFB, 2, 0, 0, 1, 2, 3, 1, 0, 0, 0);
        push(mk("slt_neg_pos", 1, 1, 0, 0, 32'd1, 0, 32'd2, 5'd3, 0, 32'h0, 0));

        tick(); clear_inputs(); bundle(OpFn, 6'h2A, 0, 2, 32'hFFFF_FFFB, 0, 0, 1, 2, 3, 1, 0, 0, 0);
        push(mk("slt_pos_neg", 1, 1, 0, 0, 32'd0, 1, 32'hFFFF_FFFB, 5'd3, 0, 32'h0, 0));

        tick(); clear_inputs(); bundle(OpFn, 6'h07, 0, 3, 4, 0, 0, 1, 2, 3, 1, 0, 0, 0);
        push(mk("bad_funct", 1, 0, 0, 0, 32'd7, 0, 32'd4, 5'd3, 0, 32'h0, 1));

        tick(); clear_inputs(); bundle(OpBad, 6'h20, 1, 2, 9, 32'h10, 32'h100, 1, 2, 5, 1, 1, 1, 0);
        push(mk("bad_aluop", 1, 0, 1, 0, 32'h12, 0, 32'd9, 5'd5, 0, 32'h140, 1));

        tick(); clear_inputs();
        bundle(OpAdd, 6'h00, 1, 32'h1000, 32'h55, 8, 32'h200, 1, 2, 8, 1, 1, 0, 0);
        push(mk("lw_addr", 1, 1, 1, 0, 32'h1008, 0, 32'h55, 5'd8, 0, 32'h220, 0));

        tick(); clear_inputs(); bundle(OpAdd, 6'h00, 1, 32'h2000, 32'h1234, 4, 0, 1, 9, 0, 0, 0, 1, 0);
        wb_fwd_we = 1; wb_fwd_rd = 9; wb_fwd_data = 32'hCAFE;
        push(mk("sw_fwd_store", 1, 0, 0, 1, 32'h2004, 0, 32'hCAFE, 5'd0, 0, 32'h10, 0));

        tick(); clear_inputs(); bundle(OpFn, 6'h20, 0, 32'hFFFF_FFFF, 1, 0, 0, 1, 2, 3, 1, 0, 0, 0);
        push(mk("add_wrap", 1, 1, 0, 0, 32'h0, 1, 32'h1, 5'd3, 0, 32'h0, 0));

        tick(); clear_inputs(); bundle(OpFn, 6'h24, 0, 32'hF0F0, 32'hFF00, 0, 0, 1, 2, 3, 1, 0, 0, 0);
        push(mk("and", 1, 1, 0, 0, 32'hF000, 0, 32'hFF00, 5'd3, 0, 32'h0, 0));

        tick(); clear_inputs(); bundle(OpFn, 6'h25, 0, 32'hF0F0, 32'hFF00, 0, 0, 1, 2, 3, 1, 0, 0, 0);
        push(mk("or", 1, 1, 0, 0, 32'hFFF0, 0, 32'hFF00, 5'd3, 0, 32'h0, 0));

        for (int i = 0; i < 3; i++) begin
            exp_t h;
            tick(); clear_inputs(); stall_in = 1;
            bundle(OpFn, 6'h20, 0, 1, 1, 4, 32'h80, 1, 2, 9, 1, 1, 1, 1);
            h = last_exp;
            h.name = $sformatf("stall_hold_%0d", i);
            push(h);
        end

        tick(); stall_in = 1; flush_in = 1;
        push(zero_exp("stall_flush"));

        tick(); clear_inputs(); bundle(OpFn, 6'h20, 0, 5, 10, 0, 32'h40, 1, 2, 4, 1, 0, 0, 0);
        push(mk("recover_add", 1, 1, 0, 0, 32'd15, 0, 32'd10, 5'd4, 0, 32'h40, 0));

        tick(); rst = 1;
        push(zero_exp("mid_reset"));

        tick(); rst = 0; id_valid = 0;
        push(zero_exp("bubble"));

        tick(); id_valid = 1;
        push(mk("after_bubble", 1, 1, 0, 0, 32'd15, 0, 32'd10, 5'd4, 0, 32'h40, 0));

        tick(); clear_inputs();
        push(zero_exp("idle"));

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
